// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
package wb_bus_arbiter_pkg;

  // Bus width used across the CPU register/bus datapath.
  localparam int unsigned RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  // Level of rst_n that holds the design in reset.
  localparam logic RstEnable = 1'b0;

  // Arbiter state encodings; the GNT codes double as the one-hot grant vector.
  typedef enum logic [1:0] {
    ArbIdle = 2'b00,
    ArbGnt0 = 2'b01,
    ArbGnt1 = 2'b10
  } arb_state_e;

  // Which master owned the bus most recently (loses the next tie).
  typedef enum logic {
    LastM0 = 1'b0,
    LastM1 = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall counter for the arbiter: counts unacknowledged strobe cycles of the
// current owner and flags the cycle on which the limit is reached.
module wb_arb_watchdog
  import wb_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [CW-1:0] Limit = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Clear has priority over counting so an ack on the limit cycle wins.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Timeout is a single-cycle pulse while the stalled strobe sits at the limit.
  always_comb begin
    timeout_o = en_i && !clr_i && (count_q == Limit);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter. Round-robin grant held for a whole
// cyc, one dead cycle between owners, watchdog abort with error to the owner.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int unsigned DW      = RegBus,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0 (data side)
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [DW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  input  logic [3:0]    m0_sel_i,
  output logic [DW-1:0] m0_data_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  // master 1 (instruction side)
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [DW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  input  logic [3:0]    m1_sel_i,
  output logic [DW-1:0] m1_data_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  // slave
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [DW-1:0] s_addr_o,
  output logic [DW-1:0] s_data_o,
  output logic [3:0]    s_sel_o,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  arb_state_e state_q, state_d;
  arb_owner_e last_q, last_d;
  logic       own_stb;
  logic       wd_clr;
  logic       wd_en;
  logic       timeout;

  // Watchdog control: held clear while idle or on ack, counts owner stalls.
  always_comb begin
    own_stb = 1'b0;
    unique case (state_q)
      ArbGnt0: own_stb = m0_stb_i;
      ArbGnt1: own_stb = m1_stb_i;
      default: own_stb = 1'b0;
    endcase
    wd_clr = (state_q == ArbIdle) || s_ack_i;
    wd_en  = own_stb && !s_ack_i;
  end

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .timeout_o (timeout)
  );

  // Next-state: arbitrate in IDLE, release the owner on cyc drop or abort.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ArbIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_q == LastM1) begin
            state_d = ArbGnt0;
            last_d  = LastM0;
          end else begin
            state_d = ArbGnt1;
            last_d  = LastM1;
          end
        end else if (m0_cyc_i) begin
          state_d = ArbGnt0;
          last_d  = LastM0;
        end else if (m1_cyc_i) begin
          state_d = ArbGnt1;
          last_d  = LastM1;
        end
      end
      ArbGnt0: if (!m0_cyc_i || timeout) state_d = ArbIdle;
      ArbGnt1: if (!m1_cyc_i || timeout) state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  // Bus muxes: pass the owner through, kill cyc/stb on the abort cycle.
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    gnt_o     = 2'b00;
    unique case (state_q)
      ArbGnt0: begin
        s_cyc_o   = m0_cyc_i && !timeout;
        s_stb_o   = m0_stb_i && !timeout;
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_sel_o   = m0_sel_i;
        m0_ack_o  = s_ack_i;
        m0_err_o  = timeout;
        m0_data_o = (s_ack_i && !m0_we_i) ? s_data_i : '0;
        gnt_o     = 2'b01;
      end
      ArbGnt1: begin
        s_cyc_o   = m1_cyc_i && !timeout;
        s_stb_o   = m1_stb_i && !timeout;
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_sel_o   = m1_sel_i;
        m1_ack_o  = s_ack_i;
        m1_err_o  = timeout;
        m1_data_o = (s_ack_i && !m1_we_i) ? s_data_i : '0;
        gnt_o     = 2'b10;
      end
      default: ;
    endcase
  end

  // State and last-owner registers; m1 is "last" out of reset so m0 wins ties.
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      state_q <= ArbIdle;
      last_q  <= LastM1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus a randomized
// run compared against a behavioural owner/stall model.
module tb_wb_bus_arbiter;

  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [DW-1:0] m0_addr_i, m0_data_i, m0_data_o;
  logic [3:0]    m0_sel_i;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [DW-1:0] m1_addr_i, m1_data_i, m1_data_o;
  logic [3:0]    m1_sel_i;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [DW-1:0] s_addr_o, s_data_o, s_data_i;
  logic [3:0]    s_sel_o;
  logic          s_ack_i;
  logic [1:0]    gnt_o;

  int checks = 0;
  int failures = 0;

  wb_bus_arbiter #(
    .DW      (DW),
    .TIMEOUT (TIMEOUT),
    .CW      (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_cyc_i  (m0_cyc_i),
    .m0_stb_i  (m0_stb_i),
    .m0_we_i   (m0_we_i),
    .m0_addr_i (m0_addr_i),
    .m0_data_i (m0_data_i),
    .m0_sel_i  (m0_sel_i),
    .m0_data_o (m0_data_o),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_cyc_i  (m1_cyc_i),
    .m1_stb_i  (m1_stb_i),
    .m1_we_i   (m1_we_i),
    .m1_addr_i (m1_addr_i),
    .m1_data_i (m1_data_i),
    .m1_sel_i  (m1_sel_i),
    .m1_data_o (m1_data_o),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_sel_o   (s_sel_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i),
    .gnt_o     (gnt_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen at +4.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    {m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i} = '0;
    {m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i} = '0;
    s_ack_i  = 1'b0;
    s_data_i = '0;
  endtask

  task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                          input logic [DW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] sel);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
    m0_addr_i = addr; m0_data_i = data; m0_sel_i = sel;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                          input logic [DW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] sel);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
    m1_addr_i = addr; m1_data_i = data; m1_sel_i = sel;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_m0(1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 4'hf);
    drive_m1(1'b1, 1'b1, 1'b0, 32'h3333_3333, 32'h4444_4444, 4'h3);
    s_ack_i = 1'b1;
    s_data_i = 32'h5555_5555;
    tick();
    tick();
    #3;
    checks++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, gnt_o} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, gnt_o}, 9'b0);
    end
    checks++;
    if ({s_addr_o, s_data_o} !== 64'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {s_addr_o, s_data_o});
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_data_o, m1_data_o} !== '0) begin
      failures++;
      $display("FAIL reset_master got ack/err=%b%b%b%b d0=%h d1=%h exp all 0",
               m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_data_o, m1_data_o);
    end
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read;
    do_reset();
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hf);
    #3;
    checks++;
    if ({gnt_o, s_cyc_o} !== 3'b000) begin
      failures++;
      $display("FAIL read_latency got gnt/cyc=%b exp=000", {gnt_o, s_cyc_o});
    end
    tick();
    #3;
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o} !== 6'b01_1100 || s_addr_o !== 32'h1000) begin
      failures++;
      $display("FAIL read_grant got=%b addr=%h exp=011100 addr=00001000",
               {gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o}, s_addr_o);
    end
    tick();
    #3;
    checks++;
    if ({m0_ack_o, m0_err_o} !== 2'b00) begin
      failures++;
      $display("FAIL read_wait got ack/err=%b exp=00", {m0_ack_o, m0_err_o});
    end
    tick();
    s_ack_i = 1'b1;
    s_data_i = 32'hDEAD_BEEF;
    #3;
    checks++;
    if ({gnt_o, m0_ack_o, m0_err_o} !== 4'b0110 || m0_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL read_ack got=%b data=%h exp=0110 data=deadbeef",
               {gnt_o, m0_ack_o, m0_err_o}, m0_data_o);
    end
    checks++;
    if ({m1_ack_o, m1_err_o} !== 2'b00 || m1_data_o !== 32'h0) begin
      failures++;
      $display("FAIL read_other got ack/err=%b data=%h exp=00 data=0",
               {m1_ack_o, m1_err_o}, m1_data_o);
    end
    tick();
    clear_inputs();
    tick();
    #3;
    checks++;
    if ({gnt_o, s_cyc_o} !== 3'b000) begin
      failures++;
      $display("FAIL read_release got gnt/cyc=%b exp=000", {gnt_o, s_cyc_o});
    end
  endtask

  task automatic test_tie;
    do_reset();
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'hf);
    drive_m1(1'b1, 1'b1, 1'b0, 32'h0000_00B0, 32'h0, 4'hf);
    tick();
    #3;
    checks++;
    if (gnt_o !== 2'b01 || s_addr_o !== 32'hA0 || m1_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL tie_first got gnt=%b addr=%h m1_ack=%b exp gnt=01 addr=a0 m1_ack=0",
               gnt_o, s_addr_o, m1_ack_o);
    end
    tick();
    m0_cyc_i = 1'b0;
    m0_stb_i = 1'b0;
    tick();
    #3;
    checks++;
    if ({gnt_o, s_cyc_o} !== 3'b000) begin
      failures++;
      $display("FAIL tie_dead_cycle got gnt/cyc=%b exp=000", {gnt_o, s_cyc_o});
    end
    tick();
    #3;
    checks++;
    if (gnt_o !== 2'b10 || s_addr_o !== 32'hB0) begin
      failures++;
      $display("FAIL tie_second_owner got gnt=%b addr=%h exp gnt=10 addr=b0", gnt_o, s_addr_o);
    end
    drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_00A4, 32'h0, 4'hf);
    drive_m1(1'b1, 1'b1, 1'b0, 32'h0000_00B4, 32'h0, 4'hf);
    tick();
    #3;
    checks++;
    if (gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL tie_again got gnt=%b exp=01", gnt_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    drive_m1(1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'b1111);
    tick();
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hf);
    #3;
    checks++;
    if ({gnt_o, s_we_o, s_sel_o} !== 7'b10_1_1111 || s_data_o !== 32'h1234_5678
        || s_addr_o !== 32'h2000) begin
      failures++;
      $display("FAIL b2b_write got=%b data=%h addr=%h exp=1011111 data=12345678 addr=2000",
               {gnt_o, s_we_o, s_sel_o}, s_data_o, s_addr_o);
    end
    s_ack_i = 1'b1;
    s_data_i = 32'hFFFF_0000;
    #1;
    checks++;
    if ({m1_ack_o, m0_ack_o} !== 2'b10 || m1_data_o !== 32'h0) begin
      failures++;
      $display("FAIL b2b_write_ack got m1/m0 ack=%b m1_data=%h exp=10 data=0",
               {m1_ack_o, m0_ack_o}, m1_data_o);
    end
    tick();
    s_ack_i = 1'b0;
    drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    drive_m1(1'b1, 1'b1, 1'b1, 32'h0000_2004, 32'h8765_4321, 4'b1111);
    #3;
    checks++;
    if (gnt_o !== 2'b00) begin
      failures++;
      $display("FAIL b2b_gap got gnt=%b exp=00", gnt_o);
    end
    tick();
    #3;
    checks++;
    if (gnt_o !== 2'b01 || s_addr_o !== 32'h3000) begin
      failures++;
      $display("FAIL b2b_round_robin got gnt=%b addr=%h exp gnt=01 addr=3000", gnt_o, s_addr_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_watchdog;
    do_reset();
    drive_m1(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hf);
    tick();
    for (int stall = 1; stall <= TIMEOUT; stall++) begin
      #3;
      checks++;
      if (m1_err_o !== (stall == TIMEOUT) || s_cyc_o !== (stall != TIMEOUT)
          || s_stb_o !== (stall != TIMEOUT) || m1_ack_o !== 1'b0) begin
        failures++;
        $display("FAIL wdog_stall%0d got err=%b cyc=%b stb=%b ack=%b exp err=%b cyc=%b",
                 stall, m1_err_o, s_cyc_o, s_stb_o, m1_ack_o,
                 stall == TIMEOUT, stall != TIMEOUT);
      end
      tick();
    end
    #3;
    checks++;
    if ({gnt_o, m1_err_o} !== 3'b000) begin
      failures++;
      $display("FAIL wdog_idle got gnt/err=%b exp=000", {gnt_o, m1_err_o});
    end
    tick();
    #3;
    checks++;
    if ({gnt_o, m1_err_o} !== 3'b100) begin
      failures++;
      $display("FAIL wdog_regrant got gnt/err=%b exp=100", {gnt_o, m1_err_o});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_ack_boundary;
    do_reset();
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hf);
    tick();
    for (int stall = 1; stall < TIMEOUT; stall++) begin
      tick();
    end
    s_ack_i = 1'b1;
    s_data_i = 32'hA5A5_5A5A;
    #3;
    checks++;
    if ({m0_ack_o, m0_err_o, s_cyc_o} !== 3'b101 || m0_data_o !== 32'hA5A5_5A5A) begin
      failures++;
      $display("FAIL edge_ack got ack/err/cyc=%b data=%h exp=101 data=a5a55a5a",
               {m0_ack_o, m0_err_o, s_cyc_o}, m0_data_o);
    end
    tick();
    s_ack_i = 1'b0;
    // Counter must restart from zero after the ack.
    for (int k = 1; k <= TIMEOUT; k++) begin
      #3;
      checks++;
      if (gnt_o !== 2'b01 || m0_err_o !== (k == TIMEOUT)) begin
        failures++;
        $display("FAIL edge_hold%0d got gnt=%b err=%b exp gnt=01 err=%b",
                 k, gnt_o, m0_err_o, k == TIMEOUT);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hf);
    tick();
    #3;
    checks++;
    if (gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_grant got gnt=%b exp=01", gnt_o);
    end
    rst_n = 1'b0;
    tick();
    s_ack_i = 1'b1;
    s_data_i = 32'hCAFE_F00D;
    drive_m1(1'b1, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hf);
    #3;
    checks++;
    if ({s_cyc_o, s_stb_o, s_we_o, gnt_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 9'b0
        || m0_data_o !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_drop got=%b d0=%h exp=000000000 d0=0",
               {s_cyc_o, s_stb_o, s_we_o, gnt_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o},
               m0_data_o);
    end
    s_ack_i = 1'b0;
    rst_n = 1'b1;
    tick();
    #3;
    checks++;
    if (gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_tie got gnt=%b exp=01", gnt_o);
    end
    clear_inputs();
    tick();
  endtask

  // Reference: owner 0=none 1=m0 2=m1; last owner loses ties; stalls counts
  // strobed, unacked cycles since the grant or the latest ack.
  task automatic test_random;
    int unsigned owner, last, stalls;
    logic o_cyc, o_stb, o_we, tmo;
    logic [DW-1:0] o_addr, o_data, e_d0, e_d1;
    logic [3:0] o_sel;
    logic [1:0] e_gnt;
    logic [12:0] e_ctrl, a_ctrl;
    do_reset();
    owner = 0;
    last = 2;
    stalls = 0;
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      m0_cyc_i = m0_cyc_i ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      m1_cyc_i = m1_cyc_i ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom);
      m1_we_i = 1'($urandom);
      m0_addr_i = $urandom; m0_data_i = $urandom; m0_sel_i = 4'($urandom);
      m1_addr_i = $urandom; m1_data_i = $urandom; m1_sel_i = 4'($urandom);
      s_ack_i = ($urandom_range(0, 3) == 0);
      s_data_i = $urandom;
      #3;
      o_cyc = (owner == 1) ? m0_cyc_i : (owner == 2) ? m1_cyc_i : 1'b0;
      o_stb = (owner == 1) ? m0_stb_i : (owner == 2) ? m1_stb_i : 1'b0;
      o_we = (owner == 1) ? m0_we_i : (owner == 2) ? m1_we_i : 1'b0;
      o_addr = (owner == 1) ? m0_addr_i : (owner == 2) ? m1_addr_i : '0;
      o_data = (owner == 1) ? m0_data_i : (owner == 2) ? m1_data_i : '0;
      o_sel = (owner == 1) ? m0_sel_i : (owner == 2) ? m1_sel_i : 4'h0;
      tmo = (owner != 0) && o_stb && !s_ack_i && (stalls == TIMEOUT - 1);
      e_gnt = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      e_ctrl = {e_gnt, o_cyc && !tmo, o_stb && !tmo, o_we, o_sel,
                (owner == 1) && s_ack_i, (owner == 1) && tmo,
                (owner == 2) && s_ack_i, (owner == 2) && tmo};
      a_ctrl = {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
      e_d0 = (owner == 1 && s_ack_i && !m0_we_i) ? s_data_i : '0;
      e_d1 = (owner == 2 && s_ack_i && !m1_we_i) ? s_data_i : '0;
      checks++;
      if (a_ctrl !== e_ctrl) begin
        failures++;
        $display("FAIL rand_ctrl cycle=%0d got=%b exp=%b", n, a_ctrl, e_ctrl);
      end
      checks++;
      if ({s_addr_o, s_data_o} !== {o_addr, o_data}) begin
        failures++;
        $display("FAIL rand_bus cycle=%0d got=%h exp=%h", n, {s_addr_o, s_data_o},
                 {o_addr, o_data});
      end
      checks++;
      if ({m0_data_o, m1_data_o} !== {e_d0, e_d1}) begin
        failures++;
        $display("FAIL rand_rdata cycle=%0d got=%h exp=%h", n, {m0_data_o, m1_data_o},
                 {e_d0, e_d1});
      end
      if (!rst_n) begin
        owner = 0;
        last = 2;
        stalls = 0;
      end else if (owner == 0) begin
        if (m0_cyc_i && m1_cyc_i) owner = (last == 1) ? 2 : 1;
        else if (m0_cyc_i) owner = 1;
        else if (m1_cyc_i) owner = 2;
        if (owner != 0) begin
          last = owner;
          stalls = 0;
        end
      end else if (!o_cyc || tmo) begin
        owner = 0;
      end else if (s_ack_i) begin
        stalls = 0;
      end else if (o_stb) begin
        stalls++;
      end
      tick();
    end
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_watchdog();
    test_ack_boundary();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter.
- Shares the single external Wishbone bus between the data-side bus interface (m0) and the instruction-side bus interface (m1) of the CPU.
- Round-robin grant is held for a whole cycle (cyc high).
- A watchdog ends transactions whose slave never acks and signals an error to the owning master.

Parameters:
- DW, 32, data/address width (matches RegBus).
- TIMEOUT, 255, cycles in GRANT with no ack before abort; legal range 1..65535.
- CW, 16, width of watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
- m0_addr_i, m0_data_i  in  DW each  master 0 address / write data
- m0_sel_i  in  4  master 0 byte select
- m0_data_o  out  DW  read data to master 0
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge / watchdog error
- m1_*  same set as m0_*  master 1 (instruction side)
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave bus controls
- s_addr_o, s_data_o  out  DW each  slave address / write data
- s_sel_o  out  4  slave byte select
- s_data_i  in  DW  slave read data
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = none

Behaviour:
- One clock; reset is synchronous and active-low on rst_n, sampled at the posedge of clk.
- Reset state:
  - state = IDLE, last_grant = m1 (so m0 wins the first tie), watchdog = 0.
  - All s_* outputs 0, all m*_ack_o/err_o 0, m*_data_o 0, gnt_o = 00.
- States: IDLE, GNT0, GNT1. State, last_grant and watchdog are registered; all bus outputs are combinational muxes of state.
- IDLE:
  - Request = mX_cyc_i.
  - Only one master requests: go to that master's GNTx next edge.
  - Both request: grant the master that is not last_grant.
  - On entering GNTx: last_grant <= x, watchdog <= 0.
- Latency: a request first seen in IDLE at edge N is driven on s_* during cycle N+1 (one-cycle arbitration latency).
- GNTx outputs:
  - s_cyc/stb/we/addr/data/sel = mX inputs passed straight through.
  - mX_ack_o = s_ack_i; mX_data_o = s_data_i when s_ack_i && !mX_we_i, else 0.
  - The non-granted master sees ack = 0, err = 0, data = 0.
- GNTx transitions:
  - mX_cyc_i = 0: go to IDLE. There is no direct GNT0->GNT1 hop; one dead cycle is guaranteed between owners.
  - s_ack_i = 1: watchdog <= 0; grant is held as long as mX_cyc_i stays 1.
  - mX_stb_i = 1, s_ack_i = 0: watchdog increments.
  - mX_stb_i = 0 with cyc = 1: watchdog holds.
  - watchdog == TIMEOUT-1 with stb = 1 and no ack:
    - mX_err_o = 1 for exactly that cycle.
    - s_cyc_o/s_stb_o forced 0 in that same cycle.
    - next state IDLE.
    - The master must drop cyc; if it does not, it is re-granted through normal IDLE arbitration.
- Simultaneous ack and timeout in the same cycle: ack wins; no err, watchdog clears.
- mX_err_o and mX_ack_o are never both 1.
- Reset mid-transaction: the bus drops immediately at the next edge (s_cyc_o = 0). No ack or err is produced for the aborted cycle.
- gnt_o = 01 in GNT0, 10 in GNT1, 00 in IDLE.

Decomposition:
- Shared macro file gets ARB_IDLE / ARB_GNT0 / ARB_GNT1 state encodings (2 bits) beside the existing WB_* encodings. Reuse RegBus, ZeroWord and RstEnable.
- Natural sub-module: wb_arb_watchdog (counter, clear/enable, timeout pulse output, parameterized TIMEOUT/CW). The mux and FSM stay in the top.

Test Plan:
- Single m0 read:
  - m0_cyc=stb=1, addr=0x0000_1000; slave acks on 3rd cycle with data 0xDEAD_BEEF.
  - s_cyc rises 1 cycle after request; m0_ack_o=1 with m0_data_o=0xDEAD_BEEF; gnt_o=01; m1 sees ack=0.
- Tie from reset:
  - m0 and m1 request in the same cycle.
  - m0 granted first (gnt_o=01); after m0 drops cyc, IDLE for 1 cycle, then gnt_o=10.
  - Next simultaneous tie grants m0 again.
- Back-to-back m1 writes while m0 waits:
  - m1 write 0x1234_5678, sel=4'b1111, completes and drops cyc; m0 is requesting.
  - m0 is granted next (round-robin), not m1, even if m1 re-requests immediately.
- Watchdog, TIMEOUT=4:
  - m1 stb held, slave never acks.
  - m1_err_o pulses 1 cycle at the 4th stalled cycle; s_cyc_o=0 in that cycle; state IDLE next.
- Ack on the boundary cycle:
  - s_ack_i=1 exactly at watchdog=TIMEOUT-1.
  - ack delivered, no err, grant kept while cyc=1.
- Reset mid-transaction:
  - rst_n=0 during GNT0 with stb=1.
  - Next edge: all s_* = 0, gnt_o=00, no ack/err; after release, m0 re-wins the tie.
